effect_sequencer: RTL
=====================

# effect_sequencer

Sequences the audio effect chain between the sensor and `data_processor`. It derives the target effect set from humidity (automatic) or switches (manual), applies hysteresis and debounce, then performs a click-free change: fade out, swap the enables, fade in. It drives `effect_delay/dist/iir` and a gain word to `data_processor`, and drives LED14–16. Counting is paced by the codec sample strobe (`load_done_tick`).

## Interface
Parameters:
- `HI_TH`, 70: upper humidity threshold (delay region above it).
- `LO_TH`, 40: lower humidity threshold (distortion region below it).
- `HYST`, 2: hysteresis margin applied when leaving the committed region.
- `DEBOUNCE_TICKS`, 4800: sample ticks a new target must hold before it is accepted.
- `GAIN_W`, 8: gain word width.
- `UNITY`, 128: gain value for unity; must be less than 2^GAIN_W.
- `FADE_STEP`, 1: gain change per sample tick during a fade.

Ports:
- `clk  in  1`: system clock (single clock domain).
- `rst  in  1`: reset, synchronous, active-high.
- `sample_tick  in  1`: one-cycle strobe per audio frame (`load_done_tick`).
- `humidity  in  8`: integer %RH from `sensor_ctrl`.
- `SW13  in  1`: 0 = automatic, 1 = manual.
- `SW16, SW15, SW14  in  1 each`: manual enables for delay, distortion and IIR.
- `effect_delay, effect_dist, effect_iir  out  1 each`: committed enables.
- `gain  out  GAIN_W`: output gain to `data_processor`; applied as sample·gain/UNITY.
- `busy  out  1`: high whenever the state is not RUN.
- `LED14, LED15, LED16  out  1 each`: equal `effect_delay`, `effect_dist`, `effect_iir`.

## Operation
- Committed vector is `en = {delay, dist, iir}`.
- Target, automatic mode: always one-hot, chosen by committed region.
  - Committed DIST: DELAY if humidity > HI_TH+HYST; else IIR if humidity ≥ LO_TH+HYST; else DIST.
  - Committed IIR: DELAY if humidity > HI_TH+HYST; DIST if humidity < LO_TH−HYST; else IIR.
  - Committed DELAY: DIST if humidity < LO_TH−HYST; IIR if humidity ≤ HI_TH−HYST; else DELAY.
  - Committed vector not one-hot (left over from manual mode): use the plain classification with HYST = 0.
- Target, manual mode: `{SW16, SW15, SW14}` exactly; 000 is legal (dry path).
- Debounce:
  - `cand` register plus tick counter `dcnt`.
  - When target ≠ `cand`: load `cand` = target and clear `dcnt`.
  - When target = `en`: clear `dcnt`.
  - Otherwise `dcnt` increments on each `sample_tick`.
  - `dcnt` = DEBOUNCE_TICKS−1 on a tick with `cand` ≠ `en` raises a one-cycle `accept`.
- FSM states:
  - RUN: `gain` = UNITY. On `accept`, latch `pend` = `cand` and go to FADE_OUT.
  - FADE_OUT: each tick, `gain` −= FADE_STEP, saturating at 0. Go to SWAP in the cycle after `gain` reaches 0.
  - SWAP: exactly one clk. `en` ← `pend`, then go to FADE_IN.
  - FADE_IN: each tick, `gain` += FADE_STEP, saturating at UNITY. On reaching UNITY, go to RUN. On `accept`, latch `pend` and go to FADE_OUT, starting from the current gain.
- `accept` during FADE_OUT or SWAP is ignored. Debounce keeps running and re-fires after FADE_IN resumes if the target still differs.
- A toggle of SW13 is just a target change; it goes through debounce and fade.
- Arithmetic: `gain` is unsigned GAIN_W. Saturating add/sub uses a GAIN_W+1-bit intermediate, so `gain` never wraps.

## Timing
- Reset values:
  - `en` = 001 (IIR); `cand` = 001; `dcnt` = 0.
  - `gain` = 0; state = FADE_IN; `busy` = 1.
  - LEDs = 001. Power-up therefore fades in over UNITY/FADE_STEP ticks.
- All outputs are registered; no combinational path from inputs to outputs.
- Change latency: an input change held steady → `accept` on the DEBOUNCE_TICKS-th tick → FADE_OUT entry next clk.
- Fade out from UNITY takes ⌈UNITY/FADE_STEP⌉ ticks, then 2 clks (one to leave FADE_OUT, one in SWAP); fade in takes ⌈UNITY/FADE_STEP⌉ ticks.
- Enables change only in the clk leaving SWAP, when `gain` = 0.
- `sample_tick` in the same clk as a state transition is consumed by the destination state only from the next clk.
- `rst` mid-fade: the next clk shows reset values; no partial state survives.

## Structure
- `effect_pkg`: `state_t` enum {RUN, FADE_OUT, SWAP, FADE_IN}, the enable bit-position constants, and the one-hot codes DELAY = 100, DIST = 010, IIR = 001.
- Sub-module `humidity_classifier`: purely combinational. Takes humidity, committed `en`, HI_TH, LO_TH and HYST; outputs the one-hot automatic target.
- The rest (debounce, FSM, gain) lives in `effect_sequencer`.
- In `top`, replace the existing `effect_*` and LED assigns with this block's outputs.

## Test plan
- Reset, then 128 ticks, with defaults → `gain` 0→128 in 128 ticks; `busy` drops; `en` = 001 throughout.
- Auto mode, humidity 50→75 held 4800 ticks → `accept`; fade 128→0; `en` = 100 in SWAP; fade 0→128.
- Auto mode, humidity hovers 70↔72 with `en` = 100 (IIR exit requires ≤68) → no change.
- Auto mode, humidity 50→75 for 4000 ticks, then back to 50 → `dcnt` clears; no fade.
- Manual mode, SW16/15/14 = 110, new target accepted during FADE_IN at `gain` = 60 → FADE_OUT from 60; swap to 110 after 60 ticks.
- Assert `rst` during FADE_OUT at `gain` = 37 → next clk `gain` = 0, state FADE_IN, `en` = 001.

Source files
------------

// File: rtl/effect_pkg.sv
// Shared types and constants for the effect sequencer: FSM state encoding,
// enable bit positions within en = {delay, dist, iir}, and the one-hot codes.
package effect_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } state_t;

  // Bit positions inside the committed enable vector.
  localparam int EN_DELAY = 2;
  localparam int EN_DIST  = 1;
  localparam int EN_IIR   = 0;

  // One-hot effect codes.
  localparam logic [2:0] CODE_DELAY = 3'b100;
  localparam logic [2:0] CODE_DIST  = 3'b010;
  localparam logic [2:0] CODE_IIR   = 3'b001;

  // True when the vector is exactly one of the three automatic codes.
  function automatic logic is_one_hot(input logic [2:0] v);
    return (v == CODE_DELAY) || (v == CODE_DIST) || (v == CODE_IIR);
  endfunction

endpackage

// File: rtl/humidity_classifier.sv
// Combinational humidity-to-effect mapping with hysteresis around the region
// that is currently committed. A committed vector that is not one-hot (left
// over from manual mode) gets the plain classification with no margin.
module humidity_classifier
  import effect_pkg::*;
#(
  parameter int HI_TH = 70,
  parameter int LO_TH = 40,
  parameter int HYST  = 2
) (
  input  logic [7:0] humidity,
  input  logic [2:0] en,
  output logic [2:0] target
);

  // Leaving a region needs the reading to cross the threshold by HYST.
  localparam int HI_UP = HI_TH + HYST;
  localparam int HI_DN = HI_TH - HYST;
  localparam int LO_UP = LO_TH + HYST;
  localparam int LO_DN = LO_TH - HYST;

  int hum;

  // Pick the automatic target from the committed region and the reading.
  always_comb begin
    hum    = int'(humidity);
    target = CODE_IIR;
    if (!is_one_hot(en)) begin
      if (hum > HI_TH)      target = CODE_DELAY;
      else if (hum < LO_TH) target = CODE_DIST;
      else                  target = CODE_IIR;
    end else if (en == CODE_DIST) begin
      if (hum > HI_UP)       target = CODE_DELAY;
      else if (hum >= LO_UP) target = CODE_IIR;
      else                   target = CODE_DIST;
    end else if (en == CODE_IIR) begin
      if (hum > HI_UP)      target = CODE_DELAY;
      else if (hum < LO_DN) target = CODE_DIST;
      else                  target = CODE_IIR;
    end else begin
      if (hum < LO_DN)       target = CODE_DIST;
      else if (hum <= HI_DN) target = CODE_IIR;
      else                   target = CODE_DELAY;
    end
  end

endmodule

// File: rtl/effect_sequencer.sv
// Effect chain sequencer: selects the target effect set (automatic from
// humidity or manual from switches), debounces it in sample ticks, and
// performs a click-free change by fading the gain to zero, swapping the
// enables while silent, and fading back up to unity.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | steady, gain = UNITY, waiting for an accepted change
// FADE_OUT | gain ramps down per tick; leaves the clk after gain hits 0
// SWAP     | single clk, committed enables take the pending vector
// FADE_IN  | gain ramps up per tick; a new accept reverses direction
module effect_sequencer
  import effect_pkg::*;
#(
  parameter int HI_TH          = 70,
  parameter int LO_TH          = 40,
  parameter int HYST           = 2,
  parameter int DEBOUNCE_TICKS = 4800,
  parameter int GAIN_W         = 8,
  parameter int UNITY          = 128,
  parameter int FADE_STEP      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic [7:0]        humidity,
  input  logic              SW13,
  input  logic              SW16,
  input  logic              SW15,
  input  logic              SW14,
  output logic              effect_delay,
  output logic              effect_dist,
  output logic              effect_iir,
  output logic [GAIN_W-1:0] gain,
  output logic              busy,
  output logic              LED14,
  output logic              LED15,
  output logic              LED16
);

  // Counter wide enough to hold DEBOUNCE_TICKS-1, at least one bit.
  localparam int DCNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_TICKS - 1);

  localparam logic [GAIN_W-1:0] UNITY_G = GAIN_W'(UNITY);
  localparam logic [GAIN_W:0]   UNITY_X = (GAIN_W + 1)'(UNITY);
  localparam logic [GAIN_W:0]   STEP_X  = (GAIN_W + 1)'(FADE_STEP);

  state_t              state;
  logic [2:0]          en;
  logic [2:0]          pend;
  logic [2:0]          cand;
  logic [DCNT_W-1:0]   dcnt;
  logic [2:0]          auto_target;
  logic [2:0]          target;
  logic                accept;
  logic [GAIN_W:0]     gain_dn;
  logic [GAIN_W:0]     gain_up;
  logic [GAIN_W-1:0]   gain_dn_sat;
  logic [GAIN_W-1:0]   gain_up_sat;

  humidity_classifier #(
    .HI_TH (HI_TH),
    .LO_TH (LO_TH),
    .HYST  (HYST)
  ) u_classifier (
    .humidity (humidity),
    .en       (en),
    .target   (auto_target)
  );

  // Manual mode takes the switches verbatim, including the all-off dry path.
  always_comb begin
    target = SW13 ? {SW16, SW15, SW14} : auto_target;
  end

  // Debounce: a candidate must hold for DEBOUNCE_TICKS ticks while it differs
  // from the committed set. The counter parks at its maximum so that an
  // accept ignored mid-fade fires again on the first FADE_IN tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= CODE_IIR;
      dcnt <= '0;
    end else if (target != cand) begin
      cand <= target;
      dcnt <= '0;
    end else if (target == en) begin
      dcnt <= '0;
    end else if (sample_tick && (dcnt != DCNT_MAX)) begin
      dcnt <= dcnt + 1'b1;
    end
  end

  // Accept strobe on the tick that completes the debounce interval.
  always_comb begin
    accept = sample_tick && (target == cand) && (cand != en) && (dcnt == DCNT_MAX);
  end

  // Saturating gain steps through a one-bit-wider intermediate so the
  // gain word can never wrap at either end.
  always_comb begin
    gain_dn     = {1'b0, gain} - STEP_X;
    gain_up     = {1'b0, gain} + STEP_X;
    gain_dn_sat = gain_dn[GAIN_W] ? '0 : gain_dn[GAIN_W-1:0];
    gain_up_sat = (gain_up > UNITY_X) ? UNITY_G : gain_up[GAIN_W-1:0];
  end

  // Sequencing FSM; gain, enables and busy are all registered here. A tick
  // coinciding with a transition is handled by the source state only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FADE_IN;
      gain  <= '0;
      en    <= CODE_IIR;
      pend  <= CODE_IIR;
      busy  <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          gain <= UNITY_G;
          if (accept) begin
            pend  <= cand;
            state <= FADE_OUT;
            busy  <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (gain == '0) begin
            state <= SWAP;
          end else if (sample_tick) begin
            gain <= gain_dn_sat;
          end
        end
        SWAP: begin
          en    <= pend;
          state <= FADE_IN;
        end
        FADE_IN: begin
          if (accept) begin
            pend  <= cand;
            state <= FADE_OUT;
          end else if (gain == UNITY_G) begin
            state <= RUN;
            busy  <= 1'b0;
          end else if (sample_tick) begin
            gain <= gain_up_sat;
          end
        end
        default: begin
          state <= FADE_IN;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Enables and LEDs come straight from the committed register.
  assign effect_delay = en[EN_DELAY];
  assign effect_dist  = en[EN_DIST];
  assign effect_iir   = en[EN_IIR];
  assign LED14        = en[EN_DELAY];
  assign LED15        = en[EN_DIST];
  assign LED16        = en[EN_IIR];

endmodule
